prog_sequencer: RTL

- Driver on the processor's instruction-input side: holds a small program store, presents instruction words and mvi immediates on the processor's DIN bus, asserts Run, and waits for the processor's Done before issuing the next word.
- Sits between the bench or a loader and the proc datapath, replacing hand-driven DIN/Run stimulus.
- Detects a hung processor (no Done within a time limit) and a truncated mvi.

---
 rtl/prog_sequencer_if.sv | 30 +++
 rtl/prog_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/prog_sequencer_if.sv
// Bundle of the loader/control and processor-side signals of prog_sequencer.
// The master side is the sequencer itself; the slave side is the bench or loader.
interface prog_sequencer_if #(
  parameter int AW = 5
) ();
  logic          Start;
  logic          Abort;
  logic          LoadEn;
  logic [AW-1:0] LoadAddr;
  logic [15:0]   LoadData;
  logic [AW:0]   ProgLen;
  logic          Done;
  logic [15:0]   DIN;
  logic          Run;
  logic          Busy;
  logic          Finished;
  logic          Error;
  logic [AW-1:0] PC;
  logic [AW:0]   InstrCount;

  modport master (
    input  Start, Abort, LoadEn, LoadAddr, LoadData, ProgLen, Done,
    output DIN, Run, Busy, Finished, Error, PC, InstrCount
  );

  modport slave (
    output Start, Abort, LoadEn, LoadAddr, LoadData, ProgLen, Done,
    input  DIN, Run, Busy, Finished, Error, PC, InstrCount
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program-store driven instruction feeder for the proc datapath: issues words and
// mvi immediates on DIN with Run, waits for Done, flags hangs and truncated mvi.
module prog_sequencer #(
  parameter int         AW         = 5,
  parameter logic [2:0] MVI_OPCODE = 3'b001,
  parameter int         TIMEOUT    = 15
) (
  input logic              Clock,
  input logic              Resetn,
  prog_sequencer_if.master bus
);

  localparam int          TW    = $clog2(TIMEOUT + 1);
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic [15:0]   mem_q [DEPTH];

  logic [15:0]   cur_word;
  logic [AW:0]   pc_inc;
  logic [AW:0]   len_start;
  logic          is_mvi;

  assign cur_word  = mem_q[pc_q];
  assign pc_inc    = {1'b0, pc_q} + (AW+1)'(1);
  assign is_mvi    = (cur_word[15:13] == MVI_OPCODE);
  assign len_start = (bus.ProgLen > LEN_MAX) ? LEN_MAX : bus.ProgLen;

  // Store contents survive reset so a program can be loaded once and rerun.
  always_ff @(posedge Clock) begin
    if (state_q == S_IDLE && bus.LoadEn) begin
      mem_q[bus.LoadAddr] <= bus.LoadData;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (bus.Start) begin
          pc_d    = '0;
          cnt_d   = '0;
          len_d   = len_start;
          state_d = (bus.ProgLen == '0) ? S_DONE : S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (is_mvi && (pc_inc >= len_q)) begin
          state_d = S_ERR;
        end else if (is_mvi) begin
          pc_d    = pc_inc[AW-1:0];
          state_d = S_IMM;
        end else begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_IMM, S_WAIT: begin
        if (bus.Done) begin
          cnt_d = cnt_q + (AW+1)'(1);
          if (pc_inc == len_q) begin
            state_d = S_DONE;
          end else begin
            pc_d    = pc_inc[AW-1:0];
            state_d = S_ISSUE;
          end
        end else if (state_q == S_IMM) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything but keeps PC/InstrCount for post-mortem.
    if (bus.Abort) begin
      state_d = S_IDLE;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      tmo_d   = tmo_q;
    end
  end

  always_comb begin
    bus.Busy       = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);
    bus.Run        = bus.Busy;
    bus.DIN        = bus.Busy ? cur_word : 16'h0000;
    bus.Finished   = (state_q == S_DONE);
    bus.Error      = (state_q == S_ERR);
    bus.PC         = pc_q;
    bus.InstrCount = cnt_q;
  end

endmodule
